komut_bellek: RTL and testbench

KOMUT_BELLEK -- requirements
Module: komut_bellek

---
 rtl/komut_bellek.sv | 132 +++++++++++++
 tb/tb_komut_bellek.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/komut_bellek.sv
// komut_bellek: byte-streamed instruction memory loader with a combinational
// instruction read port.
// Optional feature macro: ADRES_DENETIM_EN. When defined, a misaligned or
// out-of-range pc seen while hazir=1 also sets the sticky hata flag.
module komut_bellek #(
  parameter int DERINLIK = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] komut,
  output logic        hazir,
  output logic        hata,
  input  logic        yukle_gecerli,
  input  logic [7:0]  yukle_bayt,
  input  logic        yukle_son,
  output logic        yukle_hazir
);

  localparam int AW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
  localparam int WW = $clog2(DERINLIK + 1);

  typedef enum logic [1:0] {
    BOS,
    YUKLE,
    CALIS
  } durum_t;

  durum_t        durum;
  durum_t        durumSonraki;
  logic [WW-1:0] wptr;
  logic [1:0]    baytSay;
  logic [31:0]   kaydirma;
  logic [31:0]   mem [DERINLIK];
  logic [DERINLIK-1:0] dolu;

  logic          kabul;
  logic          yazma;
  logic          sonYazma;
  logic [31:0]   kelime;
  logic [31:0]   kelimeAdr;
  logic          adrGecerli;
  logic [AW-1:0] memAdr;

  // The loader takes bytes until the program is complete; reset also closes it.
  assign yukle_hazir = reset & (durum != CALIS);

  // Handshake decode and little-endian placement of the incoming byte into
  // the partially assembled word; upper bytes not yet received stay zero.
  always_comb begin
    kabul    = yukle_gecerli & yukle_hazir;
    kelime   = kaydirma | ({24'h0, yukle_bayt} << {baytSay, 3'b000});
    yazma    = kabul & ((baytSay == 2'd3) | yukle_son);
    sonYazma = yazma & (yukle_son | (wptr == WW'(DERINLIK - 1)));
  end

  // Next-state logic: the load ends on the flagged last byte or when memory fills.
  always_comb begin
    durumSonraki = durum;
    case (durum)
      BOS: begin
        if (kabul) begin
          durumSonraki = sonYazma ? CALIS : YUKLE;
        end
      end
      YUKLE: begin
        if (sonYazma) begin
          durumSonraki = CALIS;
        end
      end
      CALIS: begin
        durumSonraki = CALIS;
      end
      default: begin
        durumSonraki = BOS;
      end
    endcase
  end

  // Control state, word pointer, byte assembly, written-word map and fault flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      durum    <= BOS;
      wptr     <= '0;
      baytSay  <= 2'd0;
      kaydirma <= 32'h0;
      hazir    <= 1'b0;
      hata     <= 1'b0;
      dolu     <= '0;
    end else begin
      durum <= durumSonraki;
      hazir <= (durumSonraki == CALIS);
      if (yazma) begin
        dolu[wptr[AW-1:0]] <= 1'b1;
        wptr               <= wptr + 1'b1;
        baytSay            <= 2'd0;
        kaydirma           <= 32'h0;
      end else if (kabul) begin
        kaydirma <= kelime;
        baytSay  <= baytSay + 2'd1;
      end
      if ((durum == CALIS) && yukle_gecerli) begin
        hata <= 1'b1;
      end
`ifdef ADRES_DENETIM_EN
      if (hazir && ((pc[1:0] != 2'b00) || !adrGecerli)) begin
        hata <= 1'b1;
      end
`endif
    end
  end

  // Word storage; words never written read back as zero through the dolu map,
  // so the array itself needs no clearing.
  always_ff @(posedge clk) begin
    if (yazma) begin
      mem[wptr[AW-1:0]] <= kelime;
    end
  end

  // Combinational fetch: only valid once the program is loaded and pc is in range.
  always_comb begin
    kelimeAdr  = pc >> 2;
    adrGecerli = kelimeAdr < 32'(DERINLIK);
    memAdr     = kelimeAdr[AW-1:0];
    komut      = 32'h0;
    if (hazir && adrGecerli && dolu[memAdr]) begin
      komut = mem[memAdr];
    end
  end

endmodule

// File: tb/tb_komut_bellek.sv
// tb_komut_bellek: randomized scoreboard bench for komut_bellek.
module tb_komut_bellek;

  localparam int DERINLIK = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] komut;
  logic        hazir;
  logic        hata;
  logic        yukle_gecerli = 1'b0;
  logic [7:0]  yukle_bayt = 8'h0;
  logic        yukle_son = 1'b0;
  logic        yukle_hazir;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] deger;
  } beklenti_t;

  beklenti_t  sb[$];
  logic [7:0] program_[$];
  logic [7:0] yukleme[$];

  logic beklenenHata;

  komut_bellek #(.DERINLIK(DERINLIK)) dut (
    .clk(clk),
    .reset(reset),
    .pc(pc),
    .komut(komut),
    .hazir(hazir),
    .hata(hata),
    .yukle_gecerli(yukle_gecerli),
    .yukle_bayt(yukle_bayt),
    .yukle_son(yukle_son),
    .yukle_hazir(yukle_hazir)
  );

  always #5 clk = ~clk;

  // Reference: the word at pc>>2 is the little-endian group of accepted bytes.
  function automatic logic [31:0] beklenenKomut(input logic [31:0] adr);
    logic [31:0] w;
    int taban;
    w = 32'h0;
    if ((adr >> 2) >= DERINLIK) return 32'h0;
    taban = int'(adr >> 2) * 4;
    for (int k = 0; k < 4; k++) begin
      if (taban + k < program_.size()) w = w | (32'(program_[taban + k]) << (8 * k));
    end
    return w;
  endfunction

  task automatic checkOutput(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    compared++;
    if (gercek !== beklenen) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", ad, gercek, beklenen, $time);
    end
  endtask

  // Monitor: whenever the DUT presents a valid instruction, retire one expectation.
  always @(negedge clk) begin
    beklenti_t e;
    if (hazir && sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput($sformatf("komut pc=%h", e.adr), komut, e.deger);
    end
  end

  task automatic resetle();
    reset = 1'b0;
    yukle_gecerli = 1'b0;
    yukle_son = 1'b0;
    #2;
    checkOutput("yukle_hazir in reset", 32'(yukle_hazir), 32'd0);
    checkOutput("hazir in reset", 32'(hazir), 32'd0);
    checkOutput("hata in reset", 32'(hata), 32'd0);
    program_.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checkOutput("yukle_hazir after reset", 32'(yukle_hazir), 32'd1);
    checkOutput("komut after reset", komut, 32'h0);
    @(posedge clk); #1;
  endtask

  // One byte handshake; the loader must be ready while the program is open.
  task automatic applyStimulus(input logic [7:0] b, input logic son);
    yukle_gecerli = 1'b1;
    yukle_bayt = b;
    yukle_son = son;
    pc = $urandom_range(0, 255);
    #1;
    checkOutput("yukle_hazir during load", 32'(yukle_hazir), 32'd1);
    checkOutput("hazir during load", 32'(hazir), 32'd0);
    checkOutput("komut during load", komut, 32'h0);
    program_.push_back(b);
    @(posedge clk); #1;
  endtask

  task automatic loadProgram(input logic sonKullan, input logic bosluk);
    for (int i = 0; i < yukleme.size(); i++) begin
      if (bosluk && $urandom_range(0, 3) == 0) begin
        yukle_gecerli = 1'b0;
        yukle_son = 1'b0;
        @(posedge clk); #1;
      end
      applyStimulus(yukleme[i], sonKullan && (i == yukleme.size() - 1));
    end
  endtask

  task automatic finishLoad();
    yukle_gecerli = 1'b0;
    yukle_son = 1'b0;
    checkOutput("hazir after last write", 32'(hazir), 32'd1);
    checkOutput("yukle_hazir in CALIS", 32'(yukle_hazir), 32'd0);
  endtask

  task automatic readPc(input logic [31:0] adr);
    pc = adr;
    sb.push_back('{adr, beklenenKomut(adr)});
    @(posedge clk); #1;
  endtask

  initial begin
`ifdef ADRES_DENETIM_EN
    beklenenHata = 1'b1;
`else
    beklenenHata = 1'b0;
`endif
    resetle();

    // Single word with the last-byte flag.
    yukleme.delete();
    yukleme.push_back(8'h13); yukleme.push_back(8'h00);
    yukleme.push_back(8'h50); yukleme.push_back(8'h00);
    loadProgram(1'b1, 1'b0);
    finishLoad();
    readPc(32'h0);
    checkOutput("word0 literal", komut, 32'h00500013);
    readPc(32'h4);
    for (int i = 0; i < 6; i++) readPc(32'($urandom_range(0, DERINLIK + 4)) << 2);

    // Partial trailing word is zero-filled.
    resetle();
    yukleme.delete();
    yukleme.push_back(8'hAA); yukleme.push_back(8'hBB); yukleme.push_back(8'hCC);
    yukleme.push_back(8'hDD); yukleme.push_back(8'hEE);
    loadProgram(1'b1, 1'b0);
    finishLoad();
    readPc(32'h0);
    checkOutput("AA..DD literal", komut, 32'hDDCCBBAA);
    readPc(32'h4);
    checkOutput("EE zero-filled literal", komut, 32'h000000EE);
    readPc(32'h8);
    checkOutput("unwritten word literal", komut, 32'h0);

    // Full memory without a last-byte flag, then an overflow byte.
    resetle();
    yukleme.delete();
    for (int i = 0; i < DERINLIK * 4; i++) yukleme.push_back(8'($urandom));
    loadProgram(1'b0, 1'b0);
    finishLoad();
    checkOutput("hata after full load", 32'(hata), 32'd0);
    for (int i = 0; i < DERINLIK; i++) readPc(32'(i) << 2);
    readPc(32'(DERINLIK) << 2);
    yukle_gecerli = 1'b1;
    yukle_bayt = 8'h5A;
    @(posedge clk); #1;
    yukle_gecerli = 1'b0;
    checkOutput("hata on byte in CALIS", 32'(hata), 32'd1);
    readPc(32'h0);

    // Reset mid-load abandons the partial word.
    resetle();
    for (int i = 0; i < 6; i++) applyStimulus(8'($urandom), 1'b0);
    #3;
    resetle();
    yukleme.delete();
    yukleme.push_back(8'h01); yukleme.push_back(8'h02);
    yukleme.push_back(8'h03); yukleme.push_back(8'h04);
    loadProgram(1'b1, 1'b0);
    finishLoad();
    readPc(32'h0);
    checkOutput("reload word0 literal", komut, 32'h04030201);
    readPc(32'h4);
    checkOutput("reload word1 literal", komut, 32'h0);

    // Misaligned and out-of-range addresses.
    resetle();
    loadProgram(1'b1, 1'b0);
    finishLoad();
    pc = 32'h2;
    #1;
    checkOutput("komut misaligned pc", komut, 32'h04030201);
    @(posedge clk); #1;
    checkOutput("hata misaligned pc", 32'(hata), 32'(beklenenHata));
    resetle();
    loadProgram(1'b1, 1'b0);
    finishLoad();
    pc = 32'h100;
    #1;
    checkOutput("komut out-of-range pc", komut, 32'h0);
    @(posedge clk); #1;
    checkOutput("hata out-of-range pc", 32'(hata), 32'(beklenenHata));

    // Back-to-back stream with valid held high from BOS into YUKLE.
    resetle();
    yukleme.delete();
    for (int i = 0; i < 22; i++) yukleme.push_back(8'($urandom));
    loadProgram(1'b1, 1'b0);
    finishLoad();
    for (int i = 0; i < 8; i++) readPc(32'(i) << 2);

    // Random programs with random gaps and lengths past the memory size.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 300);
      resetle();
      yukleme.delete();
      for (int i = 0; i < ((n > DERINLIK * 4) ? DERINLIK * 4 : n); i++) yukleme.push_back(8'($urandom));
      loadProgram(n <= DERINLIK * 4, 1'b1);
      finishLoad();
      for (int i = 0; i < 20; i++) readPc(32'($urandom_range(0, DERINLIK + 4)) << 2);
    end

    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("scoreboard drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
